// File: rtl/param_reg_file_sb.sv
// Parametrised register file with asynchronous clear, optional hardwired-zero
// register 0, optional write-to-read bypass and a per-register busy scoreboard.
module param_reg_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              ren1,
    input  logic              ren2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_reg,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic wr_legal;
    logic alloc_legal;

    // Writes and allocs aimed at a hardwired-zero register are dropped.
    always_comb begin
        wr_legal    = we;
        alloc_legal = alloc_en;
        if (HAS_ZERO && (waddr == '0)) begin
            wr_legal = 1'b0;
        end
        if (HAS_ZERO && (alloc_reg == '0)) begin
            alloc_legal = 1'b0;
        end
    end

    // Register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_legal) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Scoreboard next state: alloc beats a completing write to the same index.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (alloc_legal && (alloc_reg == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (we && (waddr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        if (HAS_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    // Population count of the post-edge scoreboard, so busy_cnt tracks busy_q.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs_q[addr];
        if (HAS_BYP && wr_legal && (waddr == addr)) begin
            val = wdata;
        end
        if (HAS_ZERO && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    // A forwarded operand is never reported busy.
    function automatic logic busy_port(input logic [ADDR_W-1:0] addr);
        logic b;
        b = busy_q[addr];
        if (HAS_BYP && wr_legal && (waddr == addr)) begin
            b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
        busy1  = busy_port(raddr1);
        busy2  = busy_port(raddr2);
        stall  = (ren1 & busy1) | (ren2 & busy2);
    end

    assign busy_cnt = cnt_q;

endmodule
